// File: rtl/exu_pkg.sv
// Shared definitions for the execute-stage writeback merger.
//   DEF_XLEN / DEF_REG_AW : default data and register-address widths
//   wb_req_t              : one buffered writeback {addr, data}
//   rr_next()             : round-robin successor of an index modulo n
package exu_pkg;

   localparam int DEF_XLEN   = 64;
   localparam int DEF_REG_AW = 5;

   typedef struct packed {
      logic [DEF_REG_AW-1:0] addr;
      logic [DEF_XLEN-1:0]   data;
   } wb_req_t;

   // Next index after cur in a ring of n entries (n need not be a power of two).
   function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
      return (cur + 1 >= n) ? 0 : cur + 1;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source writeback FIFO.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push, pop  : enqueue din / dequeue the head; the caller only pops when
//                non-empty and only pushes when not full or popping the same cycle
//   din, dout  : entry in / head entry out (head visible combinationally)
//   full, empty, count : occupancy, derived from wrap-around pointers
module wb_fifo
   import exu_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = wb_req_t
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  T                       din,
   output T                       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   T mem [DEPTH];

   // Pointers carry one extra MSB so full and empty are distinguishable.
   logic [AW:0] wr_ptr_reg;
   logic [AW:0] rd_ptr_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg[AW-1:0]] <= din;
   end

   // Head read is combinational so an entry pushed at one edge can be
   // granted and registered onto a write port at the very next edge.
   assign dout  = mem[rd_ptr_reg[AW-1:0]];
   assign count = wr_ptr_reg - rd_ptr_reg;
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/exu_wb_merge.sv
// Writeback merger: NSRC independent writeback sources are buffered in
// per-source FIFOs and drained round-robin onto NWP register-file write ports.
//   clk, rst_n   : clock, synchronous active-low reset
//   src_vld/addr/data : packed per-source writeback requests
//   wp_vld/addr/data  : registered write-port outputs
//   pending_mask : reg r has a write buffered or currently on a port
//   wb_stall     : some FIFO is at DEPTH-1 or more entries
//   ovf_err      : sticky, a request was dropped at a full FIFO
//   waw_err      : sticky, a request targeted a pending reg or collided with another source
module exu_wb_merge
   import exu_pkg::*;
#(
   parameter int NSRC   = 3,
   parameter int NWP    = 1,
   parameter int DEPTH  = 4,
   parameter int XLEN   = DEF_XLEN,
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NSRC-1:0]         src_vld,
   input  logic [NSRC*REG_AW-1:0]  src_addr,
   input  logic [NSRC*XLEN-1:0]    src_data,
   output logic [NWP-1:0]          wp_vld,
   output logic [NWP*REG_AW-1:0]   wp_addr,
   output logic [NWP*XLEN-1:0]     wp_data,
   output logic [(2**REG_AW)-1:0]  pending_mask,
   output logic                    wb_stall,
   output logic                    ovf_err,
   output logic                    waw_err
);

   localparam int NREG  = 2**REG_AW;
   localparam int PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;
   localparam int FCW   = $clog2(DEPTH) + 1;
   // A register can be outstanding in every FIFO slot plus every port.
   localparam int CNT_W = $clog2(NSRC*DEPTH + NWP + 1);

   typedef struct packed {
      logic [REG_AW-1:0] addr;
      logic [XLEN-1:0]   data;
   } req_t;

   logic [NSRC-1:0]    full;
   logic [NSRC-1:0]    empty;
   logic [NSRC-1:0]    grant;
   logic [NSRC-1:0]    live;
   logic [NSRC-1:0]    push_ok;
   logic [NSRC-1:0]    ovf_hit;
   logic [NSRC-1:0]    waw_hit;
   logic [REG_AW-1:0]  in_addr  [NSRC];
   req_t               head     [NSRC];
   logic [FCW-1:0]     fifo_cnt [NSRC];

   logic [NWP-1:0]     port_go;
   req_t               port_req [NWP];

   logic [PTR_W-1:0]   rr_ptr_reg;
   logic [PTR_W-1:0]   rr_ptr_next;
   logic [NWP-1:0]     wp_vld_reg;
   logic [NWP*REG_AW-1:0] wp_addr_reg;
   logic [NWP*XLEN-1:0]   wp_data_reg;
   logic               ovf_err_reg;
   logic               waw_err_reg;

   // ---------------- per-source FIFOs ----------------
   genvar gi;
   generate
      for (gi = 0; gi < NSRC; gi++) begin : g_src
         req_t in_req;
         assign in_req.addr = src_addr[gi*REG_AW +: REG_AW];
         assign in_req.data = src_data[gi*XLEN +: XLEN];
         assign in_addr[gi] = in_req.addr;
         // x0 writes are architecturally void and never occupy a slot.
         assign live[gi]    = src_vld[gi] && (in_req.addr != '0);
         // A full FIFO still accepts when its head leaves in the same cycle.
         assign push_ok[gi] = live[gi] && (!full[gi] || grant[gi]);

         wb_fifo #(
            .DEPTH (DEPTH),
            .T     (req_t)
         ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push_ok[gi]),
            .pop   (grant[gi]),
            .din   (in_req),
            .dout  (head[gi]),
            .full  (full[gi]),
            .empty (empty[gi]),
            .count (fifo_cnt[gi])
         );
      end
   endgenerate

   // ---------------- round-robin arbiter ----------------
   // Port k is given the k-th non-empty source found scanning from rr_ptr;
   // already-granted sources are masked out so each pass finds the next one.
   always_comb begin
      logic [NSRC-1:0]  avail;
      logic             found;
      logic [PTR_W-1:0] idx;
      logic [PTR_W-1:0] last;
      avail   = ~empty;
      grant   = '0;
      port_go = '0;
      last    = rr_ptr_reg;
      for (int k = 0; k < NWP; k++) begin
         port_req[k] = '0;
         found = 1'b0;
         idx   = rr_ptr_reg;
         for (int s = 0; s < NSRC; s++) begin
            if (!found && avail[idx]) begin
               found       = 1'b1;
               avail[idx]  = 1'b0;
               grant[idx]  = 1'b1;
               port_go[k]  = 1'b1;
               port_req[k] = head[idx];
               last        = idx;
            end
            idx = PTR_W'(rr_next(32'(idx), NSRC));
         end
      end
      rr_ptr_next = (|grant) ? PTR_W'(rr_next(32'(last), NSRC)) : rr_ptr_reg;
   end

   // ---------------- error detection ----------------
   always_comb begin
      ovf_hit = '0;
      waw_hit = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (live[i]) begin
            if (full[i] && !grant[i])        ovf_hit[i] = 1'b1;
            if (pending_mask[in_addr[i]])    waw_hit[i] = 1'b1;
            for (int j = 0; j < NSRC; j++) begin
               if (j != i && live[j] && in_addr[j] == in_addr[i]) waw_hit[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      wb_stall = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (fifo_cnt[i] >= FCW'(DEPTH-1)) wb_stall = 1'b1;
      end
   end

   // ---------------- write ports and sticky flags ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_reg  <= '0;
         wp_vld_reg  <= '0;
         wp_addr_reg <= '0;
         wp_data_reg <= '0;
         ovf_err_reg <= 1'b0;
         waw_err_reg <= 1'b0;
      end else begin
         rr_ptr_reg <= rr_ptr_next;
         wp_vld_reg <= port_go;
         for (int k = 0; k < NWP; k++) begin
            if (port_go[k]) begin
               wp_addr_reg[k*REG_AW +: REG_AW] <= port_req[k].addr;
               wp_data_reg[k*XLEN +: XLEN]     <= port_req[k].data;
            end
         end
         if (|ovf_hit) ovf_err_reg <= 1'b1;
         if (|waw_hit) waw_err_reg <= 1'b1;
      end
   end

   // ---------------- pending-register tracking ----------------
   // One outstanding-write counter per register so that a register targeted
   // by several buffered writes stays pending until the last one retires.
   // A write retires at the edge ending its wp_vld cycle; arrivals and
   // retirements in the same edge net out, so a new push keeps the bit set.
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_reg
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;

         always_comb begin
            cnt_next = cnt_reg;
            for (int i = 0; i < NSRC; i++) begin
               if (push_ok[i] && in_addr[i] == REG_AW'(gi)) cnt_next = cnt_next + CNT_W'(1);
            end
            for (int k = 0; k < NWP; k++) begin
               if (wp_vld_reg[k] && wp_addr_reg[k*REG_AW +: REG_AW] == REG_AW'(gi))
                  cnt_next = cnt_next - CNT_W'(1);
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) cnt_reg <= '0;
            else        cnt_reg <= cnt_next;
         end

         assign pending_mask[gi] = |cnt_reg;
      end
   endgenerate

   assign wp_vld  = wp_vld_reg;
   assign wp_addr = wp_addr_reg;
   assign wp_data = wp_data_reg;
   assign ovf_err = ovf_err_reg;
   assign waw_err = waw_err_reg;

endmodule

// File: tb/tb_exu_wb_merge.sv
// Bench for exu_wb_merge (NSRC=3, NWP=1, DEPTH=4). The stimulus process keeps
// a queue-based model of the buffered writes and pushes the expected response
// of every clock edge; an independent monitor pops and compares.
module tb_exu_wb_merge;

   localparam int NSRC   = 3;
   localparam int NWP    = 1;
   localparam int DEPTH  = 4;
   localparam int XLEN   = 64;
   localparam int REG_AW = 5;
   localparam int NREG   = 32;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NSRC-1:0]         src_vld;
   logic [NSRC*REG_AW-1:0]  src_addr;
   logic [NSRC*XLEN-1:0]    src_data;
   logic [NWP-1:0]          wp_vld;
   logic [NWP*REG_AW-1:0]   wp_addr;
   logic [NWP*XLEN-1:0]     wp_data;
   logic [NREG-1:0]         pending_mask;
   logic                    wb_stall;
   logic                    ovf_err;
   logic                    waw_err;

   exu_wb_merge #(
      .NSRC(NSRC), .NWP(NWP), .DEPTH(DEPTH), .XLEN(XLEN), .REG_AW(REG_AW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .src_vld      (src_vld),
      .src_addr     (src_addr),
      .src_data     (src_data),
      .wp_vld       (wp_vld),
      .wp_addr      (wp_addr),
      .wp_data      (wp_data),
      .pending_mask (pending_mask),
      .wb_stall     (wb_stall),
      .ovf_err      (ovf_err),
      .waw_err      (waw_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [REG_AW-1:0] addr;
      logic [XLEN-1:0]   data;
      int                cyc;
   } wr_t;

   typedef struct {
      logic              vld;
      logic [NREG-1:0]   mask;
      logic              stall;
      logic              ovf;
      logic              waw;
      logic              zero;
      int                cyc;
   } st_t;

   wr_t exp_wr [$];
   st_t exp_st [$];

   // behavioural model state
   wr_t               mq [NSRC][$];
   logic              m_port_vld;
   logic [REG_AW-1:0] m_port_addr;
   int                m_rr;
   logic              m_ovf;
   logic              m_waw;
   int                cyc;

   // per-cycle source request staging
   logic              s_vld  [NSRC];
   logic [REG_AW-1:0] s_addr [NSRC];
   logic [XLEN-1:0]   s_data [NSRC];

   int checks   = 0;
   int failures = 0;
   int mon_cyc  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, mon_cyc, act, req);
      end
   endtask

   function automatic logic is_pending(input logic [REG_AW-1:0] a);
      logic p;
      p = m_port_vld && (m_port_addr == a);
      for (int i = 0; i < NSRC; i++)
         foreach (mq[i][e]) if (mq[i][e].addr == a) p = 1'b1;
      return p;
   endfunction

   function automatic logic [NREG-1:0] model_mask();
      logic [NREG-1:0] m;
      m = '0;
      for (int i = 0; i < NSRC; i++)
         foreach (mq[i][e]) m[mq[i][e].addr] = 1'b1;
      if (m_port_vld) m[m_port_addr] = 1'b1;
      return m;
   endfunction

   task automatic set_src(input int i, input logic [REG_AW-1:0] a, input logic [XLEN-1:0] d);
      s_vld[i]  = 1'b1;
      s_addr[i] = a;
      s_data[i] = d;
   endtask

   // Drive one cycle of stimulus and predict what the following edge produces.
   task automatic step(input logic rst);
      st_t e;
      wr_t w;
      int  g;
      @(negedge clk);
      rst_n = ~rst;
      for (int i = 0; i < NSRC; i++) begin
         src_vld[i]                   = s_vld[i];
         src_addr[i*REG_AW +: REG_AW] = s_addr[i];
         src_data[i*XLEN +: XLEN]     = s_data[i];
      end
      e = '{vld: 1'b0, mask: '0, stall: 1'b0, ovf: 1'b0, waw: 1'b0, zero: 1'b0, cyc: cyc};
      if (rst) begin
         for (int i = 0; i < NSRC; i++) mq[i].delete();
         m_port_vld = 1'b0;
         m_rr  = 0;
         m_ovf = 1'b0;
         m_waw = 1'b0;
         e.zero = 1'b1;
      end else begin
         // ordering violations are judged against what is outstanding now
         for (int i = 0; i < NSRC; i++) begin
            if (s_vld[i] && s_addr[i] != 0) begin
               if (is_pending(s_addr[i])) m_waw = 1'b1;
               for (int j = 0; j < NSRC; j++)
                  if (j != i && s_vld[j] && s_addr[j] == s_addr[i]) m_waw = 1'b1;
            end
         end
         // the first non-empty source from the round-robin pointer drains
         g = -1;
         for (int s = 0; s < NSRC; s++)
            if (g < 0 && mq[(m_rr + s) % NSRC].size() > 0) g = (m_rr + s) % NSRC;
         m_port_vld = 1'b0;
         if (g >= 0) begin
            w = mq[g].pop_front();
            w.cyc = cyc;
            exp_wr.push_back(w);
            m_port_vld  = 1'b1;
            m_port_addr = w.addr;
            m_rr = (g + 1) % NSRC;
         end
         // arrivals fill the slot freed by this cycle's drain
         for (int i = 0; i < NSRC; i++) begin
            if (s_vld[i] && s_addr[i] != 0) begin
               if (mq[i].size() < DEPTH) begin
                  w.addr = s_addr[i];
                  w.data = s_data[i];
                  w.cyc  = 0;
                  mq[i].push_back(w);
               end else begin
                  m_ovf = 1'b1;
               end
            end
         end
         e.vld = m_port_vld;
      end
      e.mask = model_mask();
      for (int i = 0; i < NSRC; i++) if (mq[i].size() >= DEPTH - 1) e.stall = 1'b1;
      e.ovf = m_ovf;
      e.waw = m_waw;
      exp_st.push_back(e);
      cyc++;
      for (int i = 0; i < NSRC; i++) s_vld[i] = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) step(1'b0);
   endtask

   function automatic logic [XLEN-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // ---------------- monitor ----------------
   initial begin
      st_t e;
      wr_t w;
      forever begin
         @(posedge clk);
         #1;
         if (exp_st.size() != 0) begin
            e = exp_st.pop_front();
            mon_cyc = e.cyc;
            chk("wp_vld", 64'(wp_vld), 64'(e.vld));
            chk("pending_mask", 64'(pending_mask), 64'(e.mask));
            chk("wb_stall", 64'(wb_stall), 64'(e.stall));
            chk("ovf_err", 64'(ovf_err), 64'(e.ovf));
            chk("waw_err", 64'(waw_err), 64'(e.waw));
            if (e.zero) begin
               chk("wp_addr_reset", 64'(wp_addr), 64'd0);
               chk("wp_data_reset", 64'(wp_data), 64'd0);
            end
            if (wp_vld[0] === 1'b1) begin
               if (exp_wr.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_write cyc=%0d actual addr=%0d required=none", mon_cyc, wp_addr);
               end else begin
                  w = exp_wr.pop_front();
                  chk("wr_addr", 64'(wp_addr), 64'(w.addr));
                  chk("wr_data", 64'(wp_data), w.data);
                  chk("wr_cycle", 64'(mon_cyc), 64'(w.cyc));
                  $display("WR cyc=%0d addr=x%0d data=0x%0h", mon_cyc, wp_addr, wp_data);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; src_vld = '0; src_addr = '0; src_data = '0;
      m_port_vld = 1'b0; m_port_addr = '0; m_rr = 0; m_ovf = 1'b0; m_waw = 1'b0; cyc = 0;
      for (int i = 0; i < NSRC; i++) begin s_vld[i] = 1'b0; s_addr[i] = '0; s_data[i] = '0; end

      step(1'b1); step(1'b1);

      // single write x5 from source 0
      set_src(0, 5'd5, 64'h1234); step(1'b0); idle(3);

      // contention from rr_ptr=0
      step(1'b1);
      set_src(0, 5'd1, 64'h11); set_src(1, 5'd2, 64'h22); set_src(2, 5'd3, 64'h33);
      step(1'b0); idle(4);

      // x0 write is discarded
      set_src(1, 5'd0, 64'hFFFF); step(1'b0); idle(2);

      // fill up, stall and overflow
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < NSRC; i++) set_src(i, 5'(1 + i*6 + c), rnd64());
         step(1'b0);
      end
      idle(14);
      step(1'b1);

      // WAW collision on x7
      set_src(0, 5'd7, 64'hA7); set_src(1, 5'd7, 64'hB7); step(1'b0); idle(4);
      step(1'b1);

      // reset while entries are buffered
      set_src(0, 5'd10, rnd64()); set_src(1, 5'd11, rnd64()); set_src(2, 5'd12, rnd64()); step(1'b0);
      set_src(0, 5'd13, rnd64()); step(1'b0);
      step(1'b1); idle(4);

      // randomized traffic with varying load and occasional reset
      for (int c = 0; c < 400; c++) begin
         int pct;
         pct = (c < 200) ? 20 : 45;
         for (int i = 0; i < NSRC; i++)
            if ($urandom_range(99, 0) < pct)
               set_src(i, ($urandom_range(9, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1)), rnd64());
         step($urandom_range(79, 0) == 0);
      end
      idle(16);

      @(posedge clk);
      #2;
      chk("status_queue_drained", 64'(exp_st.size()), 64'd0);
      chk("write_queue_drained", 64'(exp_wr.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
